// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM encoding, count width
// and the header-length classification used when the second count byte arrives.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } ldr_state_e;

    localparam int CNT_W = 16;

    // An empty image skips straight to the checksum; an oversize one cannot fit the memory.
    function automatic ldr_state_e len_next_state(input logic [CNT_W-1:0] cnt,
                                                  input logic [CNT_W:0]   depth);
        ldr_state_e nxt;
        if (cnt == {CNT_W{1'b0}}) begin
            nxt = CSUM;
        end else if ({1'b0, cnt} > depth) begin
            nxt = ERR;
        end else begin
            nxt = DATA;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// 8->32 little-endian word assembler: bytes shift in from the top so the first
// byte of a group lands in [7:0]; o_word_valid flags the 4th byte of each group.
module byte_assembler (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clr,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  bcnt_q, bcnt_d;

    // The word is combinational so the caller can register it on the 4th-byte cycle.
    assign o_word       = {i_byte, shreg_q[31:8]};
    assign o_word_valid = i_valid && (bcnt_q == 2'd3);

    // Next shift-register contents and byte position.
    always_comb begin
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        if (i_clr) begin
            shreg_d = 32'd0;
            bcnt_d  = 2'd0;
        end else if (i_valid) begin
            shreg_d = o_word;
            bcnt_d  = bcnt_q + 2'd1;
        end else begin
            shreg_d = shreg_q;
            bcnt_d  = bcnt_q;
        end
    end

    // Assembler state registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shreg_q <= 32'd0;
            bcnt_q  <= 2'd0;
        end else begin
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a counted, XOR-checksummed byte image into imem writes and
// keeps the core held in reset until a complete, valid image has been received.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    input  logic              i_reload,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_core_hold,
    output logic              o_done,
    output logic              o_err
);

    localparam int             WIDX_W  = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    ldr_state_e        state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer_s;
    logic              asm_valid_s;
    logic              asm_clr_s;
    logic [31:0]       asm_word_s;
    logic              asm_word_valid_s;
    logic              last_word_s;

    assign xfer_s      = i_byte_valid && ready_q;
    assign asm_valid_s = xfer_s && (state_q == DATA);
    assign last_word_s = (CNT_W'(widx_q) == (cnt_q - 16'd1));

    byte_assembler u_asm (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clr        (asm_clr_s),
        .i_valid      (asm_valid_s),
        .i_byte       (i_byte),
        .o_word       (asm_word_s),
        .o_word_valid (asm_word_valid_s)
    );

    // FSM next state, word index, checksum, write strobe and registered output decode.
    always_comb begin
        state_d   = state_q;
        cnt_lo_d  = cnt_lo_q;
        cnt_d     = cnt_q;
        widx_d    = widx_q;
        csum_d    = csum_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        asm_clr_s = 1'b0;

        case (state_q)
            LEN0: begin
                if (xfer_s) begin
                    cnt_lo_d = i_byte;
                    state_d  = LEN1;
                end else begin
                    state_d  = LEN0;
                end
            end
            LEN1: begin
                if (xfer_s) begin
                    cnt_d   = {i_byte, cnt_lo_q};
                    state_d = len_next_state({i_byte, cnt_lo_q}, DEPTH_C);
                end else begin
                    state_d = LEN1;
                end
            end
            DATA: begin
                if (xfer_s) begin
                    csum_d = csum_q ^ i_byte;
                    if (asm_word_valid_s) begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'({widx_q, 2'b00});
                        wdata_d = asm_word_s;
                        widx_d  = widx_q + WIDX_W'(1);
                        state_d = last_word_s ? CSUM : DATA;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            CSUM: begin
                if (xfer_s) begin
                    state_d = (i_byte == csum_q) ? DONE : ERR;
                end else begin
                    state_d = CSUM;
                end
            end
            DONE, ERR: begin
                if (i_reload) begin
                    state_d   = LEN0;
                    cnt_lo_d  = 8'd0;
                    cnt_d     = {CNT_W{1'b0}};
                    widx_d    = {WIDX_W{1'b0}};
                    csum_d    = 8'd0;
                    asm_clr_s = 1'b1;
                end else begin
                    state_d   = state_q;
                end
            end
            default: begin
                state_d = ERR;
            end
        endcase

        // Outputs follow the state being entered so they are available straight from flops.
        case (state_d)
            DONE: begin
                ready_d = 1'b0;
                hold_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = 1'b0;
            end
            ERR: begin
                ready_d = 1'b0;
                hold_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b1;
            end
            default: begin
                ready_d = 1'b1;
                hold_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    // Loader state and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= LEN0;
            cnt_lo_q <= 8'd0;
            cnt_q    <= {CNT_W{1'b0}};
            widx_q   <= {WIDX_W{1'b0}};
            csum_q   <= 8'd0;
            we_q     <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= 32'd0;
            ready_q  <= 1'b1;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_lo_q <= cnt_lo_d;
            cnt_q    <= cnt_d;
            widx_q   <= widx_d;
            csum_q   <= csum_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_byte_ready = ready_q;
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_core_hold  = hold_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule
